// File: rtl/maria_bus_pkg.sv
// Shared definitions for the MARIA-side bus arbiter.
//
// Contents:
//   arb_state_e     - arbiter FSM state encoding
//   FastDivDefault  - mclk0 ticks per fast CPU cycle (1.79 MHz)
//   SlowDivDefault  - mclk0 ticks per slow CPU cycle (1.19 MHz, TIA/RIOT)
//   TiaAddrHi       - cpu_addr[15:5] value selecting TIA space
//   RiotAddrHi      - cpu_addr[15:7] value selecting RIOT space
//   is_slow_addr()  - slow-region decode from cpu_addr[15:5]
package maria_bus_pkg;

  typedef enum logic [1:0] {
    StCpuRun     = 2'd0,
    StHaltWait   = 2'd1,
    StDmaOwn     = 2'd2,
    StTurnaround = 2'd3
  } arb_state_e;

  localparam int unsigned FastDivDefault = 4;
  localparam int unsigned SlowDivDefault = 6;

  // Phase counter width; divisors must be in 2..2**PhaseWidth.
  localparam int unsigned PhaseWidth = 8;

  localparam int unsigned AddrWidth  = 16;
  localparam int unsigned StealWidth = 16;

  localparam logic [10:0] TiaAddrHi  = 11'h000;
  localparam logic [8:0]  RiotAddrHi = 9'b000000101;

  // addr_hi is cpu_addr[15:5]; RIOT compares the upper nine of those bits.
  function automatic logic is_slow_addr(input logic [10:0] addr_hi);
    return (addr_hi == TiaAddrHi) || (addr_hi[10:2] == RiotAddrHi);
  endfunction

endpackage

// File: rtl/cpu_cycle_timer.sv
// CPU cycle-length generator.
//
// Counts mclk0 ticks through one 6502 bus cycle. The cycle length is chosen at
// phase 0 from the address on the bus (TIA/RIOT are slow) and held until the
// cycle closes. While run_i is low the phase is parked at 0.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   tick_i         mclk0 clock enable; nothing advances while low
//   run_i          high while the CPU owns cycle timing (CPU_RUN / HALT_WAIT)
//   cpu_addr_hi_i  cpu_addr[15:5], used for the slow-region decode
//   cycle_end_o    combinational: this tick closes the current cycle
//   cpu_ce_o       registered one-clk pulse following the closing tick
//   slow_cycle_o   current cycle is slow
module cpu_cycle_timer
  import maria_bus_pkg::*;
#(
  parameter int unsigned FastDiv = FastDivDefault,
  parameter int unsigned SlowDiv = SlowDivDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        run_i,
  input  logic [10:0] cpu_addr_hi_i,
  output logic        cycle_end_o,
  output logic        cpu_ce_o,
  output logic        slow_cycle_o
);

  logic [PhaseWidth-1:0] phase_q;
  logic [PhaseWidth-1:0] last_phase;
  logic                  slow_q;
  logic                  cpu_ce_q;

  // The divisor is only compared for phase >= 1, by which point slow_q already
  // holds this cycle's decode (latched on the phase-0 tick).
  always_comb begin
    last_phase  = slow_q ? PhaseWidth'(SlowDiv - 1) : PhaseWidth'(FastDiv - 1);
    cycle_end_o = tick_i && run_i && (phase_q == last_phase);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q  <= '0;
      slow_q   <= 1'b0;
      cpu_ce_q <= 1'b0;
    end else begin
      // Cleared on the next clk regardless of tick_i, so the pulse is one clk wide.
      cpu_ce_q <= cycle_end_o;
      if (tick_i) begin
        if (!run_i || cycle_end_o) begin
          phase_q <= '0;
        end else begin
          phase_q <= phase_q + 1'b1;
        end
        if (run_i && (phase_q == '0)) begin
          slow_q <= is_slow_addr(cpu_addr_hi_i);
        end
      end
    end
  end

  assign cpu_ce_o     = cpu_ce_q;
  assign slow_cycle_o = slow_q;

endmodule

// File: rtl/bus_arbiter.sv
// System bus arbiter between the 6502 CPU and the MARIA DMA engine.
//
// The CPU runs cycles of FAST_DIV or SLOW_DIV mclk0 ticks. A DMA halt request
// drops RDY at once, but the bus is only handed over at the end of a CPU read
// cycle (the 6502 ignores RDY during writes). After DMA releases the halt, one
// turnaround tick returns the address bus to the CPU before it resumes.
//
// Ports:
//   clk_sys       system clock
//   reset_n       asynchronous active-low reset
//   mclk0         master-rate clock enable; all state advances only when high
//   dma_halt_req  HALT request from the DMA controller
//   dma_drive_ab  DMA controller is driving the address bus
//   dma_addr      DMA address
//   cpu_addr      CPU address
//   cpu_rw        CPU read (1) / write (0)
//   cpu_ce        one-clk_sys pulse closing a CPU cycle
//   cpu_rdy       CPU ready (6502 RDY)
//   dma_grant     bus owned by DMA
//   slow_cycle    current CPU cycle is slow
//   bus_addr      muxed system address
//   steal_cnt     mclk0 ticks spent in DMA_OWN, saturating; cleared only by reset
module bus_arbiter
  import maria_bus_pkg::*;
#(
  parameter int unsigned FAST_DIV = FastDivDefault,
  parameter int unsigned SLOW_DIV = SlowDivDefault
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  mclk0,
  input  logic                  dma_halt_req,
  input  logic                  dma_drive_ab,
  input  logic [AddrWidth-1:0]  dma_addr,
  input  logic [AddrWidth-1:0]  cpu_addr,
  input  logic                  cpu_rw,
  output logic                  cpu_ce,
  output logic                  cpu_rdy,
  output logic                  dma_grant,
  output logic                  slow_cycle,
  output logic [AddrWidth-1:0]  bus_addr,
  output logic [StealWidth-1:0] steal_cnt
);

  arb_state_e            state_q;
  logic                  cpu_rdy_q;
  logic                  dma_grant_q;
  logic [StealWidth-1:0] steal_cnt_q;
  logic                  timer_run;
  logic                  cycle_end;

  // CPU cycle timing only advances while the CPU still owns the bus.
  always_comb begin
    timer_run = (state_q == StCpuRun) || (state_q == StHaltWait);
  end

  cpu_cycle_timer #(
    .FastDiv (FAST_DIV),
    .SlowDiv (SLOW_DIV)
  ) u_cpu_cycle_timer (
    .clk_i         (clk_sys),
    .rst_ni        (reset_n),
    .tick_i        (mclk0),
    .run_i         (timer_run),
    .cpu_addr_hi_i (cpu_addr[15:5]),
    .cycle_end_o   (cycle_end),
    .cpu_ce_o      (cpu_ce),
    .slow_cycle_o  (slow_cycle)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StCpuRun;
      cpu_rdy_q   <= 1'b1;
      dma_grant_q <= 1'b0;
    end else if (mclk0) begin
      case (state_q)
        StCpuRun: begin
          if (dma_halt_req) begin
            state_q   <= StHaltWait;
            cpu_rdy_q <= 1'b0;
          end
        end
        StHaltWait: begin
          // A withdrawn request wins over a grant on the same tick.
          if (!dma_halt_req) begin
            state_q   <= StCpuRun;
            cpu_rdy_q <= 1'b1;
          end else if (cycle_end && cpu_rw) begin
            state_q     <= StDmaOwn;
            dma_grant_q <= 1'b1;
          end
        end
        StDmaOwn: begin
          if (!dma_halt_req) begin
            state_q     <= StTurnaround;
            dma_grant_q <= 1'b0;
          end
        end
        StTurnaround: begin
          // Halt is not sampled here; a reasserted request is seen from CPU_RUN.
          state_q   <= StCpuRun;
          cpu_rdy_q <= 1'b1;
        end
        default: begin
          state_q     <= StCpuRun;
          cpu_rdy_q   <= 1'b1;
          dma_grant_q <= 1'b0;
        end
      endcase
    end
  end

  // Counts every mclk0 tick resident in DMA_OWN, including the release tick.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      steal_cnt_q <= '0;
    end else if (mclk0 && (state_q == StDmaOwn) && (steal_cnt_q != '1)) begin
      steal_cnt_q <= steal_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus_addr = (dma_grant_q && dma_drive_ab) ? dma_addr : cpu_addr;
  end

  assign cpu_rdy   = cpu_rdy_q;
  assign dma_grant = dma_grant_q;
  assign steal_cnt = steal_cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. A monitor pops expected cpu_ce pulses
// and grant rises from scoreboard queues filled as stimulus is driven; state
// outputs are checked directly. mclk0 is high every clk_sys except a short
// gated window after the first reset release.
module tb_bus_arbiter;

  typedef struct {
    int unsigned at;
    logic        slow;
  } ce_exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        mclk0;
  logic        dma_halt_req;
  logic        dma_drive_ab;
  logic [15:0] dma_addr;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        cpu_ce;
  logic        cpu_rdy;
  logic        dma_grant;
  logic        slow_cycle;
  logic [15:0] bus_addr;
  logic [15:0] steal_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned ce_seen = 0;

  ce_exp_t     exp_ce[$];
  int unsigned exp_grant[$];

  bus_arbiter #(
    .FAST_DIV (4),
    .SLOW_DIV (6)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .mclk0        (mclk0),
    .dma_halt_req (dma_halt_req),
    .dma_drive_ab (dma_drive_ab),
    .dma_addr     (dma_addr),
    .cpu_addr     (cpu_addr),
    .cpu_rw       (cpu_rw),
    .cpu_ce       (cpu_ce),
    .cpu_rdy      (cpu_rdy),
    .dma_grant    (dma_grant),
    .slow_cycle   (slow_cycle),
    .bus_addr     (bus_addr),
    .steal_cnt    (steal_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    forever begin
      @(posedge clk_sys);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ce(input int unsigned at, input logic slow);
    ce_exp_t e;
    e.at   = at;
    e.slow = slow;
    exp_ce.push_back(e);
  endtask

  // Step to the negedge following posedge number 'target', then 1 ns more.
  task automatic tick_to(input int unsigned target);
    while (cyc < target) @(negedge clk_sys);
    #1;
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  initial begin
    ce_exp_t e;
    logic    prev_grant;
    prev_grant = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (cpu_ce === 1'b1) begin
        ce_seen = ce_seen + 1;
        if (exp_ce.size() == 0) begin
          check_eq("ce_pending", exp_ce.size(), 1);
        end else begin
          e = exp_ce.pop_front();
          check_eq("ce_cycle", cyc, e.at);
          check_eq("ce_slow", slow_cycle, e.slow);
        end
      end
      if (dma_grant === 1'b1 && prev_grant === 1'b0) begin
        if (exp_grant.size() == 0) begin
          check_eq("grant_pending", exp_grant.size(), 1);
        end else begin
          check_eq("grant_cycle", cyc, exp_grant.pop_front());
        end
      end
      prev_grant = dma_grant;
    end
  end

  initial begin
    int unsigned t;
    int unsigned s;
    int unsigned u;
    int unsigned v;
    int unsigned w;
    int unsigned x;
    int unsigned ce_base;

    reset_n      = 1'b0;
    mclk0        = 1'b1;
    dma_halt_req = 1'b0;
    dma_drive_ab = 1'b0;
    dma_addr     = 16'h1800;
    cpu_addr     = 16'hF000;
    cpu_rw       = 1'b1;

    // Reset state.
    tick_to(1);
    check_eq("rst_cpu_ce", cpu_ce, 0);
    check_eq("rst_cpu_rdy", cpu_rdy, 1);
    check_eq("rst_dma_grant", dma_grant, 0);
    check_eq("rst_slow", slow_cycle, 0);
    check_eq("rst_steal", steal_cnt, 0);

    // Release with mclk0 gated for three clocks: nothing may advance.
    tick_to(2);
    reset_n = 1'b1;
    mclk0   = 1'b0;
    tick_to(5);
    mclk0 = 1'b1;
    t = cyc;

    // Fast reads from 0xF000: cpu_ce every 4 ticks.
    push_ce(t + 4, 1'b0);
    push_ce(t + 8, 1'b0);
    push_ce(t + 12, 1'b0);
    tick_to(t + 12);

    // RIOT address 0x0284: slow, cpu_ce every 6 ticks.
    s = t + 12;
    cpu_addr = 16'h0284;
    push_ce(s + 6, 1'b1);
    push_ce(s + 12, 1'b1);
    tick_to(s + 1);
    check_eq("slow_latched", slow_cycle, 1);
    tick_to(s + 12);
    cpu_addr = 16'hF000;

    // Halt at phase 1 of a fast read: RDY drops next tick, grant after phase 3.
    u = s + 12;
    tick_to(u + 1);
    check_eq("rdy_before_halt", cpu_rdy, 1);
    dma_halt_req = 1'b1;
    push_ce(u + 4, 1'b0);
    exp_grant.push_back(u + 4);
    tick_to(u + 2);
    check_eq("rdy_after_halt", cpu_rdy, 0);
    tick_to(u + 3);
    check_eq("grant_phase3", dma_grant, 0);
    tick_to(u + 4);
    check_eq("grant_on", dma_grant, 1);
    dma_drive_ab = 1'b1;
    #1;
    check_eq("bus_dma", bus_addr, 16'h1800);
    dma_drive_ab = 1'b0;
    #1;
    check_eq("bus_cpu_nodrive", bus_addr, 16'hF000);
    dma_drive_ab = 1'b1;

    // DMA_OWN lasts ten ticks (u+5 .. u+14, the last one releasing).
    tick_to(u + 13);
    check_eq("steal_mid", steal_cnt, 9);
    dma_halt_req = 1'b0;
    tick_to(u + 14);
    check_eq("turn_grant", dma_grant, 0);
    check_eq("turn_steal", steal_cnt, 10);
    check_eq("turn_rdy", cpu_rdy, 0);
    check_eq("turn_bus", bus_addr, 16'hF000);
    push_ce(u + 19, 1'b0);
    tick_to(u + 15);
    check_eq("resume_rdy", cpu_rdy, 1);
    tick_to(u + 19);
    dma_drive_ab = 1'b0;

    // Two-tick halt pulse inside HALT_WAIT: back to CPU_RUN, no grant.
    v = u + 19;
    dma_halt_req = 1'b1;
    push_ce(v + 4, 1'b0);
    tick_to(v + 1);
    check_eq("pulse_rdy_low", cpu_rdy, 0);
    tick_to(v + 2);
    dma_halt_req = 1'b0;
    tick_to(v + 3);
    check_eq("pulse_rdy_back", cpu_rdy, 1);
    tick_to(v + 4);
    check_eq("pulse_grant", dma_grant, 0);
    check_eq("pulse_steal", steal_cnt, 10);

    // Halt across three writes then a read: grant only on the read's cpu_ce.
    w = v + 4;
    cpu_rw       = 1'b0;
    dma_halt_req = 1'b1;
    ce_base      = ce_seen;
    push_ce(w + 4, 1'b0);
    push_ce(w + 8, 1'b0);
    push_ce(w + 12, 1'b0);
    push_ce(w + 16, 1'b0);
    exp_grant.push_back(w + 16);
    tick_to(w + 12);
    cpu_rw = 1'b1;
    tick_to(w + 15);
    check_eq("wr_no_grant", dma_grant, 0);
    tick_to(w + 16);
    check_eq("wr_grant", dma_grant, 1);
    check_eq("wr_ce_count", ce_seen - ce_base, 4);

    // Release, then reassert during TURNAROUND: ignored until CPU_RUN.
    tick_to(w + 17);
    dma_halt_req = 1'b0;
    tick_to(w + 18);
    check_eq("ta2_steal", steal_cnt, 12);
    dma_halt_req = 1'b1;
    tick_to(w + 19);
    check_eq("ta2_rdy", cpu_rdy, 1);
    check_eq("ta2_grant", dma_grant, 0);
    push_ce(w + 23, 1'b0);
    exp_grant.push_back(w + 23);
    tick_to(w + 20);
    check_eq("rehalt_rdy", cpu_rdy, 0);
    tick_to(w + 23);
    check_eq("regrant", dma_grant, 1);
    dma_drive_ab = 1'b1;

    // Reset mid-DMA_OWN releases everything without waiting for a clock.
    tick_to(w + 25);
    check_eq("pre_rst_steal", steal_cnt, 14);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_grant", dma_grant, 0);
    check_eq("mid_rst_rdy", cpu_rdy, 1);
    check_eq("mid_rst_steal", steal_cnt, 0);
    check_eq("mid_rst_ce", cpu_ce, 0);
    check_eq("mid_rst_bus", bus_addr, 16'hF000);
    dma_halt_req = 1'b0;
    dma_drive_ab = 1'b0;

    // After reset: first cpu_ce FAST_DIV ticks after the first mclk0 tick.
    tick_to(cyc + 2);
    reset_n = 1'b1;
    x = cyc;
    push_ce(x + 4, 1'b0);
    tick_to(x + 6);
    check_eq("post_rst_rdy", cpu_rdy, 1);
    check_eq("post_rst_grant", dma_grant, 0);

    check_eq("ce_left", exp_ce.size(), 0);
    check_eq("grant_left", exp_grant.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the clock port is clk_sys and the reset port is reset_n.
REQ-002 Parameter FAST_DIV, default 4: mclk0 ticks per fast CPU cycle (1.79 MHz).
REQ-003 Parameter SLOW_DIV, default 6: mclk0 ticks per slow CPU cycle (1.19 MHz, TIA/RIOT).
REQ-004 Ports SHALL be:
clk_sys  in  1  system clock
reset_n  in  1  async active-low reset
mclk0  in  1  master-rate clock enable; all state advances only when high
dma_halt_req  in  1  HALT from DMA controller
dma_drive_ab  in  1  DMA controller driving address
dma_addr  in  16  DMA address
cpu_addr  in  16  CPU address
cpu_rw  in  1  CPU read (1) / write (0)
cpu_ce  out  1  one-clk_sys pulse closing a CPU cycle
cpu_rdy  out  1  CPU ready (6502 RDY)
dma_grant  out  1  bus owned by DMA
slow_cycle  out  1  current CPU cycle is slow
bus_addr  out  16  muxed system address
steal_cnt  out  16  mclk0 ticks spent in DMA_OWN, saturating

Function
REQ-005 FSM states SHALL be CPU_RUN, HALT_WAIT, DMA_OWN, TURNAROUND; all transitions occur only on mclk0.
REQ-006 Phase counter SHALL count 0..DIV-1 in CPU_RUN and HALT_WAIT; cpu_ce pulses on the mclk0 tick where phase = DIV-1; phase then wraps to 0.
REQ-007 At phase 0, slow_cycle SHALL be latched from cpu_addr: slow when cpu_addr[15:5]=0 (TIA) or cpu_addr[15:7]=9'b000000101 (RIOT); DIV = slow_cycle ? SLOW_DIV : FAST_DIV, held for the whole cycle.
REQ-008 CPU_RUN -> HALT_WAIT when dma_halt_req=1; cpu_rdy drops to 0 on the same tick.
REQ-009 HALT_WAIT -> DMA_OWN on the cpu_ce tick that ends a cycle with cpu_rw=1; on a write cycle (cpu_rw=0), the CPU cycle completes and waiting continues, with no limit on consecutive writes.
REQ-010 HALT_WAIT -> CPU_RUN with cpu_rdy=1 if dma_halt_req falls before grant; no grant pulse is produced.
REQ-011 In DMA_OWN: dma_grant=1, cpu_ce held 0, phase held 0, and steal_cnt increments per mclk0 tick, saturating at 16'hFFFF.
REQ-012 DMA_OWN -> TURNAROUND when dma_halt_req=0; TURNAROUND lasts exactly one mclk0 tick with dma_grant=0 and bus_addr=cpu_addr, then goes to CPU_RUN with cpu_rdy=1 and phase=0.
REQ-013 A dma_halt_req reasserted during TURNAROUND SHALL be ignored until CPU_RUN, then handled per REQ-008.
REQ-014 bus_addr SHALL be combinational: dma_addr when dma_grant and dma_drive_ab, else cpu_addr.
REQ-015 A slow cycle in progress at halt request SHALL run its full SLOW_DIV ticks before grant.
REQ-016 steal_cnt SHALL clear only on reset.

Reset
REQ-017 On reset_n low: state=CPU_RUN, phase=0, cpu_ce=0, cpu_rdy=1, dma_grant=0, slow_cycle=0, steal_cnt=0, all immediately and independent of clk_sys.
REQ-018 Reset asserted mid-DMA_OWN SHALL release the bus at once; after reset, the first cpu_ce occurs FAST_DIV or SLOW_DIV mclk0 ticks after the first mclk0 tick.

Structure
REQ-019 The state enum, the TIA/RIOT decode constants, and the FAST_DIV/SLOW_DIV defaults SHALL live in package maria_bus_pkg.
REQ-020 Cycle-length generation (phase counter, slow decode, cpu_ce) SHALL be sub-module cpu_cycle_timer; FSM, mux and counter stay in bus_arbiter.

Verification
REQ-021 mclk0 every clk_sys, cpu_addr=16'hF000 reads: cpu_ce every 4 ticks and slow_cycle=0; with cpu_addr=16'h0284: cpu_ce every 6 ticks and slow_cycle=1.
REQ-022 dma_halt_req=1 at phase 1 of a read cycle: cpu_rdy=0 next tick, dma_grant=1 on tick after phase 3; bus_addr=dma_addr=16'h1800 while dma_drive_ab=1.
REQ-023 Halt during three consecutive writes followed by a read: no grant until the read's cpu_ce; exactly four cpu_ce pulses occur between request and grant.
REQ-024 Halt held 10 ticks in DMA_OWN, then dropped: steal_cnt=10, one TURNAROUND tick, cpu_rdy=1, first cpu_ce 4 ticks later.
REQ-025 Halt pulse of 2 ticks inside HALT_WAIT: returns to CPU_RUN, dma_grant never asserted, steal_cnt unchanged.
REQ-026 reset_n low mid-DMA_OWN: dma_grant=0 and cpu_rdy=1 combinationally; steal_cnt=0.
